sifh_sram_arbiter: RTL and testbench

- Owns the single histogram SRAM (port A write, port B read) and shares it between three SiFH requesters: 0 = clear engine, 1 = histogram builder, 2 = peak finder.
- Grants the whole SRAM to one requester for a burst, using a req/gnt/done handshake.
- Registers and muxes the owner's strobes onto the SRAM pins and routes read data back to the owner with a valid tag.
- Sits between the SiFH top-level phase FSM's sub-engines and the SRAM macro.

---
 rtl/sifh_sram_arbiter_if.sv | 40 ++++
 rtl/sifh_sram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sifh_sram_arbiter.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sifh_sram_arbiter_if.sv
// Bus between the three SiFH requesters, the arbiter and the histogram SRAM.
// The slave modport is the arbiter side; the master modport is the requester/SRAM side.
interface sifh_sram_arbiter_if #(
  parameter int RAM_ADDR = 10,
  parameter int PEAK_MAX = 16
);
  logic [2:0]            req;
  logic [2:0]            done;
  logic [2:0]            gnt;
  logic [3*RAM_ADDR-1:0] m_waddr;
  logic [2:0]            m_wen;
  logic [3*PEAK_MAX-1:0] m_wdata;
  logic [3*RAM_ADDR-1:0] m_raddr;
  logic [2:0]            m_ren;
  logic [PEAK_MAX-1:0]   counts;
  logic [RAM_ADDR-1:0]   waddr;
  logic [RAM_ADDR-1:0]   raddr;
  logic                  wEnable;
  logic                  rEnable;
  logic                  writeFlag;
  logic                  readFlag;
  logic [PEAK_MAX-1:0]   newCounts;
  logic [PEAK_MAX-1:0]   rdata;
  logic [2:0]            rvalid;
  logic                  busy;
  logic                  err;
  logic [1:0]            err_owner;

  modport slave (
    input  req, done, m_waddr, m_wen, m_wdata, m_raddr, m_ren, counts,
    output gnt, waddr, raddr, wEnable, rEnable, writeFlag, readFlag,
           newCounts, rdata, rvalid, busy, err, err_owner
  );

  modport master (
    output req, done, m_waddr, m_wen, m_wdata, m_raddr, m_ren, counts,
    input  gnt, waddr, raddr, wEnable, rEnable, writeFlag, readFlag,
           newCounts, rdata, rvalid, busy, err, err_owner
  );
endinterface

// File: rtl/sifh_sram_arbiter.sv
// Histogram SRAM arbiter: grants the whole SRAM to one of three requesters
// (0 clear engine, 1 histogram builder, 2 peak finder) for a burst, registers
// the owner's strobes onto the SRAM pins and tags read data back to the owner.
//
// state | meaning
// IDLE  | no owner; SRAM strobes idle; grants lowest-index req on this cycle
// GRANT | owner's strobes registered onto the SRAM pins; timeout counter runs
// DRAIN | 2 cycles, strobes idle, in-flight reads return to the old owner
module sifh_sram_arbiter #(
  parameter int RAM_ADDR = 10,
  parameter int PEAK_MAX = 16,
  parameter int TIMEOUT  = 4095
) (
  input logic clk,
  input logic res,
  sifh_sram_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          drn_q, drn_d;
  logic          err_q, err_d;
  logic [1:0]    err_owner_q, err_owner_d;

  logic [2:0]          owner_oh;
  logic                owner_done;
  logic [RAM_ADDR-1:0] sel_waddr, sel_raddr;
  logic [PEAK_MAX-1:0] sel_wdata;
  logic                sel_wen, sel_ren;

  logic [RAM_ADDR-1:0] waddr_q, raddr_q;
  logic [PEAK_MAX-1:0] wdata_q;
  logic                wen_q, wflag_q, ren_n_q, rflag_q;
  logic [2:0]          rv_q;

  // Decode owner index to one-hot and pick the owner's slices off the packed buses.
  always_comb begin
    owner_oh  = 3'b001;
    sel_waddr = bus.m_waddr[0 +: RAM_ADDR];
    sel_raddr = bus.m_raddr[0 +: RAM_ADDR];
    sel_wdata = bus.m_wdata[0 +: PEAK_MAX];
    case (owner_q)
      2'd1: begin
        owner_oh  = 3'b010;
        sel_waddr = bus.m_waddr[RAM_ADDR +: RAM_ADDR];
        sel_raddr = bus.m_raddr[RAM_ADDR +: RAM_ADDR];
        sel_wdata = bus.m_wdata[PEAK_MAX +: PEAK_MAX];
      end
      2'd2: begin
        owner_oh  = 3'b100;
        sel_waddr = bus.m_waddr[2*RAM_ADDR +: RAM_ADDR];
        sel_raddr = bus.m_raddr[2*RAM_ADDR +: RAM_ADDR];
        sel_wdata = bus.m_wdata[2*PEAK_MAX +: PEAK_MAX];
      end
      default: ;
    endcase
    sel_wen    = |(bus.m_wen & owner_oh);
    sel_ren    = |(bus.m_ren & owner_oh);
    owner_done = |(bus.done & owner_oh);
    cnt_inc    = (cnt_q == TO_MAX) ? cnt_q : cnt_q + 1'b1;
  end

  // FSM state, owner, timeout counter and sticky error registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= IDLE;
      owner_q     <= 2'd0;
      cnt_q       <= '0;
      drn_q       <= 1'b0;
      err_q       <= 1'b0;
      err_owner_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      drn_q       <= drn_d;
      err_q       <= err_d;
      err_owner_q <= err_owner_d;
    end
  end

  // Next-state: fixed-priority grant, done/timeout release, two-cycle drain.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    drn_d       = drn_q;
    err_d       = err_q;
    err_owner_d = err_owner_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = GRANT;
          cnt_d   = '0;
          if (bus.req[0])      owner_d = 2'd0;
          else if (bus.req[1]) owner_d = 2'd1;
          else                 owner_d = 2'd2;
        end
      end
      GRANT: begin
        cnt_d = cnt_inc;
        if (owner_done) begin
          state_d = DRAIN;
          drn_d   = 1'b0;
        end else if (cnt_inc == TO_MAX) begin
          // Owner never signalled done: take the SRAM back and remember who.
          state_d     = DRAIN;
          drn_d       = 1'b0;
          err_d       = 1'b1;
          err_owner_d = owner_q;
        end
      end
      DRAIN: begin
        drn_d = 1'b1;
        if (drn_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // SRAM pin registers: owner's strobes during GRANT, idle strobes otherwise; read-valid pipeline.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      waddr_q <= '0;
      raddr_q <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      wflag_q <= 1'b0;
      ren_n_q <= 1'b1;
      rflag_q <= 1'b0;
      rv_q    <= 3'b000;
    end else begin
      if (state_q == GRANT) begin
        waddr_q <= sel_waddr;
        raddr_q <= sel_raddr;
        wdata_q <= sel_wdata;
        wen_q   <= sel_wen;
        wflag_q <= sel_wen;
        ren_n_q <= ~sel_ren;
        rflag_q <= sel_ren;
      end else begin
        wen_q   <= 1'b0;
        wflag_q <= 1'b0;
        ren_n_q <= 1'b1;
        rflag_q <= 1'b0;
      end
      // owner_q cannot change before a read on the pins returns, since DRAIN precedes any regrant.
      rv_q <= rflag_q ? owner_oh : 3'b000;
    end
  end

  // Outputs derived from registered state; read data passes straight from the SRAM.
  always_comb begin
    bus.gnt   = (state_q == GRANT) ? owner_oh : 3'b000;
    bus.busy  = (state_q != IDLE);
    bus.rdata = bus.counts;
  end

  assign bus.waddr     = waddr_q;
  assign bus.raddr     = raddr_q;
  assign bus.newCounts = wdata_q;
  assign bus.wEnable   = wen_q;
  assign bus.writeFlag = wflag_q;
  assign bus.rEnable   = ren_n_q;
  assign bus.readFlag  = rflag_q;
  assign bus.rvalid    = rv_q;
  assign bus.err       = err_q;
  assign bus.err_owner = err_owner_q;
endmodule

// File: tb/tb_sifh_sram_arbiter.sv
// Bench for sifh_sram_arbiter: table-driven pin checks, hand sequences for
// drain/timeout/reset, and a read-data scoreboard fed by a behavioural SRAM.
module tb_sifh_sram_arbiter;
  logic clk;
  logic res;

  sifh_sram_arbiter_if #(.RAM_ADDR(10), .PEAK_MAX(16)) bus ();

  sifh_sram_arbiter #(.RAM_ADDR(10), .PEAK_MAX(16), .TIMEOUT(8)) dut (
    .clk(clk),
    .res(res),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  oh;
    logic [15:0] data;
  } rd_t;
  rd_t sb[$];

  typedef struct {
    logic        wen;
    logic [9:0]  wa;
    logic [15:0] wd;
    logic        ren;
    logic [9:0]  ra;
    logic [9:0]  e_wa;
    logic [15:0] e_wd;
    logic        e_wen;
    logic [9:0]  e_ra;
    logic        e_ren;
  } vec_t;
  vec_t tbl[6];

  logic [15:0] mem[1024];
  logic [15:0] exp_mem[1024];

  // Behavioural SRAM: read data appears the cycle after the read strobe.
  always @(posedge clk) begin
    if (bus.readFlag && !bus.rEnable) bus.counts <= mem[bus.raddr];
    if (bus.writeFlag && bus.wEnable) mem[bus.waddr] <= bus.newCounts;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_strobes();
    bus.m_wen  = 3'b000;
    bus.m_ren  = 3'b000;
    bus.done   = 3'b000;
  endtask

  // Drive the owner's slice, optionally with random noise on the other slices.
  task automatic drive(input int own, input logic wen, input logic [9:0] wa,
                       input logic [15:0] wd, input logic ren, input logic [9:0] ra,
                       input logic noise);
    logic [29:0] wav, rav;
    logic [47:0] wdv;
    rd_t e;
    wav = noise ? 30'($urandom) : 30'd0;
    rav = noise ? 30'($urandom) : 30'd0;
    wdv = noise ? {16'($urandom), 32'($urandom)} : 48'd0;
    bus.m_wen = noise ? 3'($urandom) : 3'b000;
    bus.m_ren = noise ? 3'($urandom) : 3'b000;
    bus.done  = noise ? (3'($urandom) & ~(3'b001 << own)) : 3'b000;
    wav[own*10 +: 10] = wa;
    rav[own*10 +: 10] = ra;
    wdv[own*16 +: 16] = wd;
    bus.m_wen[own] = wen;
    bus.m_ren[own] = ren;
    bus.m_waddr = wav;
    bus.m_raddr = rav;
    bus.m_wdata = wdv;
    if (ren) begin
      e.oh   = 3'b001 << own;
      e.data = exp_mem[ra];
      sb.push_back(e);
    end
    if (wen) exp_mem[wa] = wd;
  endtask

  task automatic chk_pins(input string nm, input logic [9:0] wa, input logic [15:0] wd,
                          input logic wen, input logic [9:0] ra, input logic ren);
    chk({nm, "_waddr"}, 32'(bus.waddr), 32'(wa));
    chk({nm, "_newCounts"}, 32'(bus.newCounts), 32'(wd));
    chk({nm, "_wen_flag"}, 32'({bus.wEnable, bus.writeFlag}), 32'({wen, wen}));
    chk({nm, "_raddr"}, 32'(bus.raddr), 32'(ra));
    chk({nm, "_ren_flag"}, 32'({bus.rEnable, bus.readFlag}), 32'({~ren, ren}));
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({nm, "_rvalid"}, 32'(bus.rvalid), 32'd0);
    chk({nm, "_waddr"}, 32'(bus.waddr), 32'd0);
    chk({nm, "_raddr"}, 32'(bus.raddr), 32'd0);
    chk({nm, "_newCounts"}, 32'(bus.newCounts), 32'd0);
    chk({nm, "_strobes"}, 32'({bus.wEnable, bus.rEnable, bus.writeFlag, bus.readFlag}), 32'b0100);
    chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
    chk({nm, "_err"}, 32'({bus.err, bus.err_owner}), 32'd0);
  endtask

  // Read-data scoreboard: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    rd_t e;
    if (!res && bus.rvalid != 3'b000) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected actual=%0h required=0", bus.rvalid);
      end else begin
        e = sb.pop_front();
        chk("sb_rvalid", 32'(bus.rvalid), 32'(e.oh));
        chk("sb_rdata", 32'(bus.rdata), 32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic        r_wen, r_ren;
    logic [9:0]  r_wa, r_ra;
    logic [15:0] r_wd;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'(i * 3 + 1);
      exp_mem[i] = 16'(i * 3 + 1);
    end
    mem[12]     = 16'd42;
    exp_mem[12] = 16'd42;

    tbl[0] = '{1'b1, 10'd5,    16'd7,      1'b0, 10'd0,    10'd5,    16'd7,      1'b1, 10'd0,    1'b0};
    tbl[1] = '{1'b0, 10'd9,    16'h1234,   1'b1, 10'd5,    10'd9,    16'h1234,   1'b0, 10'd5,    1'b1};
    tbl[2] = '{1'b1, 10'd1023, 16'hFFFF,   1'b1, 10'd1023, 10'd1023, 16'hFFFF,   1'b1, 10'd1023, 1'b1};
    tbl[3] = '{1'b0, 10'd0,    16'd0,      1'b0, 10'd0,    10'd0,    16'd0,      1'b0, 10'd0,    1'b0};
    tbl[4] = '{1'b1, 10'd0,    16'd1,      1'b0, 10'd7,    10'd0,    16'd1,      1'b1, 10'd7,    1'b0};
    tbl[5] = '{1'b0, 10'd512,  16'd0,      1'b1, 10'd0,    10'd512,  16'd0,      1'b0, 10'd0,    1'b1};

    res = 1'b1;
    bus.req = 3'b000;
    bus.m_waddr = '0;
    bus.m_raddr = '0;
    bus.m_wdata = '0;
    idle_strobes();
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    res = 1'b0;
    tick();
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Builder wins over peak finder; table of owner strobes with non-owner noise.
    bus.req = 3'b110;
    tick();
    chk("t1_gnt", 32'(bus.gnt), 32'b010);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    for (int i = 0; i < 6; i++) begin
      drive(1, tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].ren, tbl[i].ra, 1'b1);
      tick();
      chk_pins($sformatf("tbl%0d", i), tbl[i].e_wa, tbl[i].e_wd, tbl[i].e_wen, tbl[i].e_ra, tbl[i].e_ren);
      chk($sformatf("tbl%0d_gnt", i), 32'(bus.gnt), 32'b010);
    end
    idle_strobes();
    bus.done = 3'b010;
    bus.req  = 3'b100;
    tick();
    chk("t1_drain1_gnt", 32'(bus.gnt), 32'd0);
    chk("t1_drain1_busy", 32'(bus.busy), 32'd1);
    chk("t1_drain1_strobes", 32'({bus.wEnable, bus.rEnable, bus.writeFlag, bus.readFlag}), 32'b0100);
    bus.done = 3'b000;
    tick();
    chk("t1_drain2_busy", 32'(bus.busy), 32'd1);
    chk("t1_drain2_gnt", 32'(bus.gnt), 32'd0);
    tick();
    chk("t1_idle_busy", 32'(bus.busy), 32'd0);
    chk("t1_idle_gnt", 32'(bus.gnt), 32'd0);
    tick();
    chk("t2_gnt", 32'(bus.gnt), 32'b100);

    // Peak finder read of address 12 returns 42 two cycles after the strobe.
    drive(2, 1'b0, 10'd0, 16'd0, 1'b1, 10'd12, 1'b0);
    tick();
    chk("t2_raddr", 32'(bus.raddr), 32'd12);
    chk("t2_ren_flag", 32'({bus.rEnable, bus.readFlag}), 32'b01);
    idle_strobes();
    tick();
    chk("t2_rvalid", 32'(bus.rvalid), 32'b100);
    chk("t2_rdata", 32'(bus.rdata), 32'd42);

    // Read in the same cycle as done: data still returns during DRAIN.
    drive(2, 1'b0, 10'd0, 16'd0, 1'b1, 10'd20, 1'b0);
    bus.done = 3'b100;
    bus.req  = 3'b011;
    tick();
    chk("t3_gnt", 32'(bus.gnt), 32'd0);
    chk("t3_raddr", 32'(bus.raddr), 32'd20);
    chk("t3_readFlag", 32'(bus.readFlag), 32'd1);
    idle_strobes();
    tick();
    chk("t3_rvalid", 32'(bus.rvalid), 32'b100);
    chk("t3_rdata", 32'(bus.rdata), 32'd61);
    chk("t3_drain_gnt", 32'(bus.gnt), 32'd0);
    chk("t3_drain_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("t3_idle_busy", 32'(bus.busy), 32'd0);
    chk("t3_idle_rvalid", 32'(bus.rvalid), 32'd0);
    tick();
    chk("t4_gnt", 32'(bus.gnt), 32'b001);

    // Clear engine never signals done: released after 8 GRANT cycles with err.
    n = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (bus.gnt == 3'b001) n++;
      else break;
    end
    chk("t4_grant_cycles", 32'(n), 32'd8);
    chk("t4_gnt", 32'(bus.gnt), 32'd0);
    chk("t4_err", 32'(bus.err), 32'd1);
    chk("t4_err_owner", 32'(bus.err_owner), 32'd0);
    chk("t4_busy", 32'(bus.busy), 32'd1);
    bus.req = 3'b010;
    tick();
    tick();
    tick();
    chk("t5_gnt", 32'(bus.gnt), 32'b010);

    // Random owner strobes with random non-owner noise.
    for (int i = 0; i < 4; i++) begin
      r_wen = 1'($urandom);
      r_ren = 1'($urandom);
      r_wa  = 10'($urandom);
      r_ra  = 10'($urandom);
      r_wd  = 16'($urandom);
      drive(1, r_wen, r_wa, r_wd, r_ren, r_ra, 1'b1);
      tick();
      chk_pins($sformatf("rnd%0d", i), r_wa, r_wd, r_wen, r_ra, r_ren);
      chk($sformatf("rnd%0d_gnt", i), 32'(bus.gnt), 32'b010);
    end
    idle_strobes();
    tick();

    // Reset with a read on the SRAM pins: everything clears, no rvalid follows.
    drive(1, 1'b0, 10'd0, 16'd0, 1'b1, 10'd33, 1'b0);
    tick();
    chk("t6_readFlag", 32'(bus.readFlag), 32'd1);
    res = 1'b1;
    #1;
    chk_reset("midres");
    sb.delete();
    idle_strobes();
    bus.req = 3'b000;
    tick();
    chk("t6_rvalid_dropped", 32'(bus.rvalid), 32'd0);
    res = 1'b0;
    bus.req = 3'b100;
    tick();
    tick();
    chk("t6_regrant", 32'(bus.gnt), 32'b100);
    bus.done = 3'b100;
    bus.req  = 3'b000;
    tick();
    bus.done = 3'b000;
    tick();
    tick();
    chk("final_busy", 32'(bus.busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
